pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning program-counter and data width in bits.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, ≥2).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its falling edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous return of pc to 0 and flush of the stack.
REQ-006 The block SHALL have port load, input, 1 bit: absolute jump, pc <= data_in.
REQ-007 The block SHALL have port inc, input, 1 bit: pc <= pc + 1.
REQ-008 The block SHALL have port jump_rel, input, 1 bit: relative branch, pc <= pc + signed data_in.
REQ-009 The block SHALL have port call, input, 1 bit: push pc+1 onto the stack, then pc <= data_in.
REQ-010 The block SHALL have port ret, input, 1 bit: pop the stack top into pc.
REQ-011 The block SHALL have port pass, input, 1 bit: combinational bypass, pc_out = data_in.
REQ-012 The block SHALL have port data_in, input, ADDR_W bits: target address or signed offset.
REQ-013 The block SHALL have port pc_out, output, ADDR_W bits: pass ? data_in : pc.
REQ-014 The block SHALL have port ras_empty, output, 1 bit: stack holds 0 entries.
REQ-015 The block SHALL have port ras_full, output, 1 bit: stack holds RAS_DEPTH entries.
REQ-016 The block SHALL have port ovf, output, 1 bit: sticky flag, call issued while full.
REQ-017 The block SHALL have port unf, output, 1 bit: sticky flag, ret issued while empty.

Function
REQ-018 Per falling edge, exactly one command SHALL take effect, priority clear > load > call > ret > jump_rel > inc > hold.
REQ-019 Lower-priority commands asserted in the same cycle SHALL be ignored entirely, with no stack or flag side effects.
REQ-020 All pc arithmetic (inc, jump_rel, call push value) SHALL be modulo 2^ADDR_W; 0xFF+1 -> 0x00 at ADDR_W=8.
REQ-021 jump_rel SHALL sign-extend data_in as two's complement; 0xFE means -2.
REQ-022 pc, stack contents and flags SHALL become visible one falling edge after the command; pass SHALL have zero latency and SHALL not alter state.
REQ-023 call when full SHALL overwrite the oldest entry (circular), keep count = RAS_DEPTH, set ovf, and still jump.
REQ-024 ret when empty SHALL leave pc unchanged and the count at 0, and set unf.
REQ-025 clear SHALL set pc = 0 and count = 0, and clear ovf and unf; stack data need not be zeroed.
REQ-026 ovf and unf SHALL hold until clear or reset.
REQ-027 Stack depth bookkeeping SHALL use a pointer plus count sized log2(RAS_DEPTH)+1 bits; ras_full and ras_empty SHALL decode from the count combinationally.

Reset
REQ-028 rst_n low SHALL immediately, independent of clk, force pc = 0, count = 0, pointer = 0, ovf = 0 and unf = 0.
REQ-029 Reset asserted mid-sequence SHALL abort any pending command; the first falling edge after rst_n rises SHALL execute normally.
REQ-030 Stack storage SHALL not require reset.

Structure
REQ-031 Command priority encoding and the default widths SHALL live in shared package cpu_ctrl_pkg, for reuse by the control unit.
REQ-032 The return-address stack SHALL be one sub-module, ras_lifo, with push/pop/flush and full/empty/ovf/unf outputs; pc_sequencer SHALL instantiate it once.

Verification
REQ-033 Reset then inc ×3 SHALL give pc_out = 0x03, ras_empty = 1, and both flags 0.
REQ-034 pc = 0xFF, inc -> pc = 0x00; pc = 0x10, jump_rel with data_in = 0xFE -> pc = 0x0E.
REQ-035 pc = 0x05, call 0x40 -> pc = 0x40, then ret -> pc = 0x06, ras_empty = 1.
REQ-036 5 nested calls from pc 0x00/0x10/0x20/0x30/0x40 -> ovf = 1, ras_full = 1; 4 rets -> pc sequence 0x41, 0x31, 0x21, 0x11; a 5th ret -> pc stays 0x11, unf = 1.
REQ-037 clear+load+inc together -> pc = 0x00, flags cleared; pass = 1 with data_in = 0xA5 -> pc_out = 0xA5 with internal pc unchanged.
REQ-038 rst_n pulsed low between edges during a call sequence -> pc_out = 0x00 asynchronously, and no push SHALL occur.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the program-counter path: default widths and
// the fixed command priority used by the sequencer and the control unit.
package cpu_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_JREL,
    CMD_RET,
    CMD_CALL,
    CMD_LOAD,
    CMD_CLEAR
  } cmd_e;

  // Exactly one command wins per edge: clear > load > call > ret > jump_rel > inc.
  function automatic cmd_e decode_cmd(input logic clear, input logic load,
                                      input logic call, input logic ret,
                                      input logic jump_rel, input logic inc);
    if (clear)         return CMD_CLEAR;
    else if (load)     return CMD_LOAD;
    else if (call)     return CMD_CALL;
    else if (ret)      return CMD_RET;
    else if (jump_rel) return CMD_JREL;
    else if (inc)      return CMD_INC;
    else               return CMD_HOLD;
  endfunction

endpackage

// File: rtl/ras_lifo.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// an empty pop is refused; both conditions latch sticky flags until flush.
module ras_lifo
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned W     = DEF_ADDR_W,
  parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;      // next slot to write; ptr_q-1 is the top
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   count_q;
  logic             ovf_q;
  logic             unf_q;

  assign top_idx  = ptr_q - PTR_ONE;
  assign top_data = mem_q[top_idx];
  assign full     = (count_q == CNT_MAX);
  assign empty    = (count_q == '0);
  assign ovf      = ovf_q;
  assign unf      = unf_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (flush) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (push) begin
      ptr_q <= ptr_q + PTR_ONE;
      if (full) ovf_q   <= 1'b1;
      else      count_q <= count_q + CNT_ONE;
    end else if (pop) begin
      if (empty) begin
        unf_q <= 1'b1;
      end else begin
        ptr_q   <= top_idx;
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are live.
  always_ff @(negedge clk) begin
    if (push && !flush) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised jump/branch/call/return control with a
// return-address stack and a zero-latency data_in bypass onto pc_out.
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              inc,
  input  logic              jump_rel,
  input  logic              call,
  input  logic              ret,
  input  logic              pass,
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ovf,
  output logic              unf
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  cmd_e              cmd;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_rel;
  logic [ADDR_W-1:0] ras_top;

  assign cmd      = decode_cmd(clear, load, call, ret, jump_rel, inc);
  assign pc_plus1 = pc_q + PC_ONE;
  // Same-width modular add is exactly pc + sign_extend(data_in).
  assign pc_rel   = pc_q + data_in;
  assign pc_out   = pass ? data_in : pc_q;

  // NOTE: combinational next-state uses blocking assignment with a default first, so no latch.
  always_comb begin
    pc_d = pc_q;
    case (cmd)
      CMD_CLEAR: pc_d = '0;
      CMD_LOAD:  pc_d = data_in;
      CMD_CALL:  pc_d = data_in;
      CMD_RET:   pc_d = ras_empty ? pc_q : ras_top;
      CMD_JREL:  pc_d = pc_rel;
      CMD_INC:   pc_d = pc_plus1;
      default:   pc_d = pc_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment only.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  ras_lifo #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (cmd == CMD_CLEAR),
    .push      (cmd == CMD_CALL),
    .pop       (cmd == CMD_RET),
    .push_data (pc_plus1),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf       (ovf),
    .unf       (unf)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues hand-computed results per
// command, and a monitor compares them once the falling edge has applied them.
module tb_pc_sequencer;

  logic       clk = 1'b1;
  logic       rst_n;
  logic       clear, load, inc, jump_rel, call, ret, pass;
  logic [7:0] data_in;
  logic [7:0] pc_out;
  logic       ras_empty, ras_full, ovf, unf;

  pc_sequencer #(.ADDR_W(8), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .inc(inc),
    .jump_rel(jump_rel), .call(call), .ret(ret), .pass(pass),
    .data_in(data_in), .pc_out(pc_out), .ras_empty(ras_empty),
    .ras_full(ras_full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [3:0] flg;  // {empty, full, ovf, unf}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one cycle after a command was driven its falling edge has passed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".pc"}, 32'(pc_out), 32'(e.pc));
        check({e.name, ".flags"}, 32'({ras_empty, ras_full, ovf, unf}), 32'(e.flg));
      end
    end
  end

  // cmd bits: {clear, load, call, ret, jump_rel, inc}
  task automatic issue(input string name, input logic [5:0] c, input logic [7:0] d,
                       input logic [7:0] exp_pc, input logic [3:0] exp_flg);
    exp_t e;
    @(posedge clk);
    #2;
    {clear, load, call, ret, jump_rel, inc} = c;
    data_in = d;
    e.name = name;
    e.pc   = exp_pc;
    e.flg  = exp_flg;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    {clear, load, call, ret, jump_rel, inc} = 6'b0;
  endtask

  localparam logic [5:0] C_CLR = 6'b100000, C_LD = 6'b010000, C_CALL = 6'b001000,
                         C_RET = 6'b000100, C_JR = 6'b000010, C_INC = 6'b000001,
                         C_NOP = 6'b000000;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {clear, load, call, ret, jump_rel, inc, pass} = 7'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    check("reset.pc", 32'(pc_out), 32'h00);
    check("reset.flags", 32'({ras_empty, ras_full, ovf, unf}), 32'b1000);
    rst_n = 1'b1;

    issue("inc1", C_INC, 8'h00, 8'h01, 4'b1000);
    issue("inc2", C_INC, 8'h00, 8'h02, 4'b1000);
    issue("inc3", C_INC, 8'h00, 8'h03, 4'b1000);
    issue("load_ff", C_LD, 8'hFF, 8'hFF, 4'b1000);
    issue("inc_wrap", C_INC, 8'h00, 8'h00, 4'b1000);
    issue("load_10", C_LD, 8'h10, 8'h10, 4'b1000);
    issue("jrel_m2", C_JR, 8'hFE, 8'h0E, 4'b1000);
    issue("jrel_p5", C_JR, 8'h05, 8'h13, 4'b1000);
    issue("load_05", C_LD, 8'h05, 8'h05, 4'b1000);
    issue("call_40", C_CALL, 8'h40, 8'h40, 4'b0000);
    issue("ret_06", C_RET, 8'h00, 8'h06, 4'b1000);

    issue("load_00", C_LD, 8'h00, 8'h00, 4'b1000);
    issue("ncall1", C_CALL, 8'h10, 8'h10, 4'b0000);
    issue("ncall2", C_CALL, 8'h20, 8'h20, 4'b0000);
    issue("ncall3", C_CALL, 8'h30, 8'h30, 4'b0000);
    issue("ncall4", C_CALL, 8'h40, 8'h40, 4'b0100);
    issue("ncall5_ovf", C_CALL, 8'h50, 8'h50, 4'b0110);
    issue("hold", C_NOP, 8'h00, 8'h50, 4'b0110);
    issue("nret1", C_RET, 8'h00, 8'h41, 4'b0010);
    issue("nret2", C_RET, 8'h00, 8'h31, 4'b0010);
    issue("nret3", C_RET, 8'h00, 8'h21, 4'b0010);
    issue("nret4", C_RET, 8'h00, 8'h11, 4'b1010);
    issue("nret5_unf", C_RET, 8'h00, 8'h11, 4'b1011);
    issue("jr_over_inc", C_JR | C_INC, 8'h02, 8'h13, 4'b1011);

    issue("clr_ld_inc", C_CLR | C_LD | C_INC, 8'h77, 8'h00, 4'b1000);
    issue("ret_over_jr", C_RET | C_JR | C_INC, 8'h04, 8'h00, 4'b1001);
    issue("clear", C_CLR, 8'h00, 8'h00, 4'b1000);
    issue("call_over_ret", C_CALL | C_RET | C_INC, 8'h30, 8'h30, 4'b0000);
    issue("load_over_call", C_LD | C_CALL, 8'h60, 8'h60, 4'b0000);
    issue("ret_01", C_RET, 8'h00, 8'h01, 4'b1000);
    idle();
    @(posedge clk);
    #2;

    pass = 1'b1;
    data_in = 8'hA5;
    #1;
    check("pass.out", 32'(pc_out), 32'hA5);
    @(posedge clk);
    #2;
    pass = 1'b0;
    #1;
    check("pass.pc_kept", 32'(pc_out), 32'h01);

    issue("call_80", C_CALL, 8'h80, 8'h80, 4'b0000);
    @(posedge clk);
    #2;
    call = 1'b1;
    data_in = 8'hC0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst.pc", 32'(pc_out), 32'h00);
    check("async_rst.flags", 32'({ras_empty, ras_full, ovf, unf}), 32'b1000);
    call = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    check("post_rst.pc", 32'(pc_out), 32'h00);
    check("post_rst.empty", 32'(ras_empty), 32'h1);
    issue("first_after_rst", C_INC, 8'h00, 8'h01, 4'b1000);
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
